// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one single-port RAM between fetch (I) and load/store (D)
//
// One access at a time: IDLE picks a winner, a grant state drives the RAM
// for one cycle and captures its combinational read data, and the following
// cycle carries a one-cycle ack back in IDLE. The RAM drive is decoded from
// the state register only, so an asynchronous reset silences ram_wren at once.

module ram_port_arbiter #(
   parameter int mem_depth = 1024,
   parameter int size      = 32,
   parameter int AW        = $clog2(mem_depth - 1)
) (
   input  logic            clock,
   input  logic            reset_n,

   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [size-1:0] i_rdata,
   output logic            i_ack,

   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [size-1:0] d_wdata,
   output logic [size-1:0] d_rdata,
   output logic            d_ack,

   output logic [AW-1:0]   ram_address,
   output logic            ram_wren,
   output logic [size-1:0] ram_data_in,
   input  logic [size-1:0] ram_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   // last_grant encoding: which port was served most recently
   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            i_ack_q, i_ack_d;
   logic            d_ack_q, d_ack_d;
   logic [size-1:0] i_rdata_q, i_rdata_d;
   logic [size-1:0] d_rdata_q, d_rdata_d;

   // A port whose ack is showing this cycle still has req high; mask it so
   // the same request is not served twice. Masks come from registered acks,
   // so there is no combinational req-to-ack path.
   logic eff_i;
   logic eff_d;

   assign eff_i = i_req & ~i_ack_q;
   assign eff_d = d_req & ~d_ack_q;

   // State, round-robin pointer, acks and captured read data
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= LG_D;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // Winner selection, RAM drive and capture of the granted access
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      ram_address  = '0;
      ram_wren     = 1'b0;
      ram_data_in  = '0;

      case (state_q)
         IDLE: begin
            if (eff_i && eff_d) begin
               // Contention: hand the RAM to whoever was not served last
               state_d = (last_grant_q == LG_D) ? GNT_I : GNT_D;
            end else if (eff_i) begin
               state_d = GNT_I;
            end else if (eff_d) begin
               state_d = GNT_D;
            end
         end

         GNT_I: begin
            ram_address  = i_addr;
            i_rdata_d    = ram_data_out;
            i_ack_d      = 1'b1;
            last_grant_d = LG_I;
            state_d      = IDLE;
         end

         GNT_D: begin
            ram_address  = d_addr;
            ram_wren     = d_we;
            ram_data_in  = d_wdata;
            // A store leaves the previous load data in place
            if (!d_we) begin
               d_rdata_d = ram_data_out;
            end
            d_ack_d      = 1'b1;
            last_grant_d = LG_D;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a transaction-level RAM model

module tb_ram_port_arbiter;

   localparam int DEPTH = 1024;
   localparam int W     = 32;
   localparam int AW    = 10;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [W-1:0]  i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [W-1:0]  d_wdata;
   logic [W-1:0]  d_rdata;
   logic          d_ack;
   logic [AW-1:0] ram_address;
   logic          ram_wren;
   logic [W-1:0]  ram_data_in;
   logic [W-1:0]  ram_data_out;

   always #5 clock = ~clock;

   ram_port_arbiter #(.mem_depth(DEPTH), .size(W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_rdata      (i_rdata),
      .i_ack        (i_ack),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_ack        (d_ack),
      .ram_address  (ram_address),
      .ram_wren     (ram_wren),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   // The RAM itself: combinational read, write on the rising edge
   logic [W-1:0] mem [0:DEPTH-1];
   assign ram_data_out = mem[ram_address];
   always @(posedge clock) begin
      if (ram_wren) mem[ram_address] <= ram_data_in;
   end

   // Reference contents: what every completed store says the RAM must hold
   logic [W-1:0] gold [0:DEPTH-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [W-1:0] exp_drd;
   int           i_times[$];
   int           d_times[$];
   int           order[$];
   int           i_wait;
   int           d_wait;
   logic         any_bad;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]  <= 32'(i) * 32'h9E37_79B1;
         gold[i]  = 32'(i) * 32'h9E37_79B1;
      end
      mem[5]  <= 32'h0000_0013;
      gold[5]  = 32'h0000_0013;

      // ---------------- reset with both requests high ----------------
      reset_n = 1'b0;
      i_req   = 1'b1;
      d_req   = 1'b1;
      d_we    = 1'b1;
      i_addr  = 10'd1;
      d_addr  = 10'd2;
      d_wdata = 32'h0000_CAFE;
      #1;
      check("rst_async_addr", 32'(ram_address), 32'd0);
      repeat (3) tick();
      check("rst_i_ack",   32'(i_ack), 32'd0);
      check("rst_d_ack",   32'(d_ack), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_wren",    32'(ram_wren), 32'd0);
      check("rst_addr",    32'(ram_address), 32'd0);
      check("rst_wdata",   ram_data_in, 32'd0);
      check("rst_mem2",    mem[2], gold[2]);

      reset_n = 1'b1;
      tick();
      check("rst_first_gnt_i", 32'(ram_address), 32'd1);
      check("rst_first_wren",  32'(ram_wren), 32'd0);
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
      check("rst_first_iack",  32'(i_ack), 32'd1);
      check("rst_first_idata", i_rdata, gold[1]);
      check("rst_first_dack",  32'(d_ack), 32'd0);
      tick();

      // ---------------- single fetch ----------------
      i_addr = 10'd5;
      i_req  = 1'b1;
      tick();
      check("fetch_c1_addr", 32'(ram_address), 32'd5);
      check("fetch_c1_ack",  32'(i_ack), 32'd0);
      tick();
      check("fetch_c2_ack",   32'(i_ack), 32'd1);
      check("fetch_c2_rdata", i_rdata, 32'h0000_0013);
      tick();
      check("fetch_no_regrant", 32'(ram_address), 32'd0);
      check("fetch_c3_ack",     32'(i_ack), 32'd0);
      i_req = 1'b0;
      tick();

      // ---------------- store then load ----------------
      exp_drd = 32'd0;
      d_we    = 1'b1;
      d_addr  = 10'd10;
      d_wdata = 32'hDEAD_BEEF;
      d_req   = 1'b1;
      tick();
      check("st_addr",  32'(ram_address), 32'd10);
      check("st_wren",  32'(ram_wren), 32'd1);
      check("st_wdata", ram_data_in, 32'hDEAD_BEEF);
      tick();
      gold[10] = 32'hDEAD_BEEF;
      check("st_ack",   32'(d_ack), 32'd1);
      check("st_mem",   mem[10], 32'hDEAD_BEEF);
      check("st_rhold", d_rdata, exp_drd);
      d_req = 1'b0;
      tick();
      d_we  = 1'b0;
      d_req = 1'b1;
      tick();
      check("ld_wren", 32'(ram_wren), 32'd0);
      tick();
      exp_drd = 32'hDEAD_BEEF;
      check("ld_ack",   32'(d_ack), 32'd1);
      check("ld_rdata", d_rdata, exp_drd);
      d_req = 1'b0;
      tick();

      // ---------------- continuous contention ----------------
      i_addr = 10'd20;
      d_addr = 10'd21;
      d_we   = 1'b0;
      i_req  = 1'b1;
      d_req  = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (i_ack) begin
            i_times.push_back(k);
            order.push_back(0);
            check("cont_idata", i_rdata, gold[20]);
         end
         if (d_ack) begin
            d_times.push_back(k);
            order.push_back(1);
            check("cont_ddata", d_rdata, gold[21]);
         end
         if (k == 16) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
      end
      exp_drd = gold[21];
      check("cont_i_count", 32'(i_times.size()), 32'd4);
      check("cont_d_count", 32'(d_times.size()), 32'd4);
      any_bad = 1'b0;
      for (int j = 1; j < order.size(); j++)
         if (order[j] == order[j-1]) any_bad = 1'b1;
      for (int j = 1; j < i_times.size(); j++)
         if (i_times[j] - i_times[j-1] != 4) any_bad = 1'b1;
      for (int j = 1; j < d_times.size(); j++)
         if (d_times[j] - d_times[j-1] != 4) any_bad = 1'b1;
      check("cont_alternate_spacing", 32'(any_bad), 32'd0);
      tick();
      tick();
      check("cont_quiet", 32'({i_ack, d_ack}), 32'd0);

      // ---------------- d_req pulse while GNT_I is active ----------------
      i_addr = 10'd6;
      i_req  = 1'b1;
      tick();
      check("drop_gnt_i", 32'(ram_address), 32'd6);
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 10'd30;
      d_wdata = 32'h0000_0055;
      tick();
      d_req = 1'b0;
      d_we  = 1'b0;
      check("drop_iack", 32'(i_ack), 32'd1);
      i_req   = 1'b0;
      any_bad = 1'b0;
      repeat (4) begin
         tick();
         if (d_ack || ram_wren) any_bad = 1'b1;
      end
      check("drop_no_daccess", 32'(any_bad), 32'd0);
      check("drop_mem30", mem[30], gold[30]);

      // ---------------- asynchronous reset during a store grant ----------------
      d_we    = 1'b1;
      d_addr  = 10'd3;
      d_wdata = 32'h0000_1234;
      d_req   = 1'b1;
      tick();
      check("rmid_wren_before", 32'(ram_wren), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("rmid_wren_async", 32'(ram_wren), 32'd0);
      check("rmid_addr_async", 32'(ram_address), 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
      check("rmid_mem3", mem[3], gold[3]);
      check("rmid_dack", 32'(d_ack), 32'd0);
      reset_n = 1'b1;
      exp_drd = 32'd0;
      tick();
      check("rmid_dack_after", 32'(d_ack), 32'd0);
      check("rmid_idle",       32'(ram_address), 32'd0);
      check("rmid_drdata",     d_rdata, exp_drd);

      // ---------------- randomized traffic against the RAM model ----------------
      i_wait = 0;
      d_wait = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (i_req) i_wait++;
         if (d_req) d_wait++;
         if (i_ack || d_ack) check("rnd_ack_excl", 32'(i_ack & d_ack), 32'd0);
         if (i_ack) begin
            check("rnd_i_spurious", 32'(i_req), 32'd1);
            check("rnd_i_rdata", i_rdata, gold[i_addr]);
            check("rnd_i_latency", 32'(i_wait >= 2 && i_wait <= 5), 32'd1);
            i_req = 1'b0;
         end
         if (d_ack) begin
            check("rnd_d_spurious", 32'(d_req), 32'd1);
            check("rnd_d_latency", 32'(d_wait >= 2 && d_wait <= 5), 32'd1);
            if (d_we) begin
               gold[d_addr] = d_wdata;
               check("rnd_st_mem", mem[d_addr], d_wdata);
            end else begin
               exp_drd = gold[d_addr];
            end
            check("rnd_d_rdata", d_rdata, exp_drd);
            d_req = 1'b0;
         end
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_addr = 10'($urandom_range(0, 15));
            i_req  = 1'b1;
            i_wait = 0;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_addr  = 10'($urandom_range(0, 15));
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_req   = 1'b1;
            d_wait  = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
